// File: rtl/tone_scheduler_if.sv
// Note-source / tone-generator bus for tone_scheduler.
// Carries the three source requests (manual, learn, AutoPlay) with their
// note/octave codes, and the scheduler's registered outputs toward the
// tone generator.
//   master : note-source side (drives requests, observes grant/tone)
//   slave  : scheduler side (samples requests, drives grant/tone)
interface tone_scheduler_if;
    logic       man_req;
    logic [3:0] man_note;
    logic [1:0] man_octave;
    logic       lrn_req;
    logic [3:0] lrn_note;
    logic [1:0] lrn_octave;
    logic       auto_req;
    logic [3:0] auto_note;
    logic [1:0] auto_octave;
    logic [2:0] grant;        // one-hot {auto, lrn, man}
    logic [3:0] tone_note;
    logic [1:0] tone_octave;
    logic       tone_en;
    logic       gap_active;

    modport master (
        output man_req, man_note, man_octave,
        output lrn_req, lrn_note, lrn_octave,
        output auto_req, auto_note, auto_octave,
        input  grant, tone_note, tone_octave, tone_en, gap_active
    );

    modport slave (
        input  man_req, man_note, man_octave,
        input  lrn_req, lrn_note, lrn_octave,
        input  auto_req, auto_note, auto_octave,
        output grant, tone_note, tone_octave, tone_en, gap_active
    );
endinterface

// File: rtl/tone_scheduler.sv
// Shares one tone generator between manual keyboard, learn-mode guide and
// AutoPlay. Fixed priority man > lrn > auto, the owner holds until it drops
// its request or a higher-priority source asks, and every ownership change
// passes through a GAP_CYCLES-long silence so the speaker never glitches.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : tone_scheduler_if.slave (requests in, registered grant/tone out)
module tone_scheduler #(
    parameter int GAP_CYCLES = 100000,
    parameter int CNT_W      = 17
) (
    input  logic              clk,
    input  logic              reset,
    tone_scheduler_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP} state_t;

    state_t           r_state,  w_state_nxt;
    logic [2:0]       r_grant,  w_grant_nxt;
    logic [3:0]       r_note,   w_note_nxt;
    logic [1:0]       r_oct,    w_oct_nxt;
    logic             r_en,     w_en_nxt;
    logic             r_gap,    w_gap_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;

    logic [2:0] w_req;
    logic [2:0] w_win;
    logic       w_own_req;
    logic       w_preempt;
    logic [2:0] w_sel;

    assign w_req = {bus.auto_req, bus.lrn_req, bus.man_req};
    assign w_win = bus.man_req ? 3'b001 :
                   bus.lrn_req ? 3'b010 :
                   bus.auto_req ? 3'b100 : 3'b000;

    assign w_own_req = |(r_grant & w_req);
    // Grant is one-hot with lower bits = higher priority, so grant-1 masks
    // exactly the sources allowed to preempt the current owner.
    assign w_preempt = |(w_req & (r_grant - 3'd1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = 1'b0;
        w_sel       = 3'b000;
        w_grant_nxt = 3'b000;
        w_note_nxt  = 4'd0;
        w_oct_nxt   = 2'd0;
        w_en_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (|w_req) begin
                    w_state_nxt = S_OWN;
                    w_sel       = w_win;
                end
            end
            S_OWN: begin
                if (!w_own_req || w_preempt) begin
                    w_state_nxt = S_GAP;
                    w_gap_nxt   = 1'b1;
                    w_cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
                end else begin
                    w_sel = r_grant;
                end
            end
            S_GAP: begin
                // Requests are ignored until the count expires; whatever is
                // asserted at that edge is arbitrated fresh.
                if (r_cnt == '0) begin
                    if (|w_req) begin
                        w_state_nxt = S_OWN;
                        w_sel       = w_win;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    w_gap_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_grant_nxt = w_sel;
        if (w_sel[0]) begin
            w_note_nxt = bus.man_note;
            w_oct_nxt  = bus.man_octave;
        end else if (w_sel[1]) begin
            w_note_nxt = bus.lrn_note;
            w_oct_nxt  = bus.lrn_octave;
        end else if (w_sel[2]) begin
            w_note_nxt = bus.auto_note;
            w_oct_nxt  = bus.auto_octave;
        end
        // A granted rest keeps ownership but silences the generator.
        w_en_nxt = (w_sel != 3'b000) && (w_note_nxt != 4'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_grant <= 3'b000;
            r_note  <= 4'd0;
            r_oct   <= 2'd0;
            r_en    <= 1'b0;
            r_gap   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_note  <= w_note_nxt;
            r_oct   <= w_oct_nxt;
            r_en    <= w_en_nxt;
            r_gap   <= w_gap_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.tone_note   = r_note;
    assign bus.tone_octave = r_oct;
    assign bus.tone_en     = r_en;
    assign bus.gap_active  = r_gap;
endmodule

// File: doc/tone_scheduler.md
Name: tone_scheduler

Overview:
Shares the single tone generator/speaker path between three note sources: manual keyboard, learn-mode guide, and the AutoPlay song player. Fixed-priority arbitration with owner hold and a forced silence gap on every ownership change, so switching sources never glitches the speaker. Sits between the note sources and the tone generator; outputs are registered.

Parameters:
GAP_CYCLES, 100000, silence cycles inserted on every owner change (1 ms at 100 MHz); legal range >= 1
CNT_W, 17, gap counter width; must hold GAP_CYCLES-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
man_req  in  1  manual keyboard requests the speaker (any key held)
man_note  in  4  manual note code; 0 = rest, 1..7 = do..si
man_octave  in  2  manual octave select
lrn_req  in  1  learn-mode source requests the speaker
lrn_note  in  4  learn-mode note code
lrn_octave  in  2  learn-mode octave
auto_req  in  1  AutoPlay requests the speaker (song running)
auto_note  in  4  AutoPlay note code
auto_octave  in  2  AutoPlay octave
grant  out  3  one-hot owner {auto, lrn, man}; 000 = no owner
tone_note  out  4  note to tone generator
tone_octave  out  2  octave to tone generator
tone_en  out  1  tone generator enable
gap_active  out  1  high while in GAP

Behaviour:
- Reset (reset=0, async): state IDLE, grant=000, tone_note=0, tone_octave=0, tone_en=0, gap_active=0, counter=0. Reset mid-GAP or mid-OWN aborts immediately; no gap on release.
- Priority: man > lrn > auto. Winner = highest-priority asserted req.
- States: IDLE, OWN, GAP; owner register holds man/lrn/auto.
- IDLE: any req at edge n -> OWN(winner) at edge n; grant and tone outputs valid after edge n (1-cycle latency from req to outputs). No gap from IDLE.
- OWN(x): each cycle register tone_note<=x_note, tone_octave<=x_octave, tone_en<=(x_note!=0); 1-cycle input-to-output latency.
- OWN(x) exit, evaluated each edge:
  - x_req=0 -> GAP.
  - higher-priority req=1 -> GAP (preemption).
  - lower-priority req never preempts; simultaneous drop of x_req and rise of another -> GAP.
- Entering GAP: grant=000, tone_en=0, tone_note=0, tone_octave=0, gap_active=1, counter loaded GAP_CYCLES-1.
- GAP: counter decrements each cycle; at count 0, arbitrate on current reqs: any -> OWN(winner) with outputs on that edge; none -> IDLE. GAP length is exactly GAP_CYCLES cycles of gap_active=1, then gap_active=0.
- GAP is not abortable by requests; a req that appears and disappears inside GAP is lost.
- A granted rest note (note=0) keeps ownership with tone_en=0.
- Octave passes through unmodified, including 2'b11.
- grant is one-hot or zero at all times; tone_en=1 implies grant!=000.

Test Plan:
- GAP_CYCLES=4. Release reset with all req=0 -> grant=000, tone_en=0; auto_req=1, auto_note=5, auto_octave=1 at edge n -> after edge n grant=100, tone_note=5, tone_octave=1, tone_en=1.
- While AUTO owns, auto_note steps 5->3->0 -> tone_note follows 1 cycle later; at note 0 tone_en=0, grant stays 100.
- AUTO owns, man_req=1, man_note=2 -> next edge GAP: grant=000, tone_en=0, gap_active=1 for exactly 4 cycles, then grant=001, tone_note=2, tone_en=1.
- MAN owns, lrn_req=1 and auto_req=1 -> no preemption, grant stays 001; man_req=0 -> 4-cycle gap, then grant=010 (lrn beats auto).
- LRN owns, lrn_req drops, no other req -> 4-cycle gap, then IDLE with grant=000; auto_req pulsed 2 cycles inside gap -> never granted.
- Assert reset=0 mid-GAP and mid-OWN -> all outputs 0 immediately (asynchronous, before next clk edge); after release with auto_req=1 -> grant=100 on first edge, no gap.
